// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with a transmit FIFO in front of it. Bytes written
//   into the FIFO are sent as serial frames. Each frame is a start bit,
//   then DATA_BITS data bits (LSB first), then an optional parity bit,
//   then STOP_BITS stop bits. Frames go out back to back for as long as
//   the FIFO has data.
//
// Parameters
//   BAUDRATE_DIVISOR  clk cycles per serial bit (>= 2)
//   DATA_BITS         data bits per frame (5..9)
//   PARITY            0 = none, 1 = odd, 2 = even
//   STOP_BITS         1 or 2
//   FIFO_DEPTH        FIFO entries, power of two, >= 2
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   wr_en        push wr_data this cycle
//   wr_data      byte to enqueue
//   full         FIFO holds FIFO_DEPTH entries (registered)
//   empty        FIFO holds no entries (registered)
//   count        FIFO occupancy (registered)
//   wr_overflow  one-cycle pulse after a write was dropped because full
//   tx_bit       serial line, idle high, driven from a flop
//   tx_busy      a frame is on the line
//   tx_done      high during the final cycle of the last stop bit
module uart_tx_fifo #(
    parameter int BAUDRATE_DIVISOR = 100_000_000 / 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          wr_overflow,
    output logic                          tx_bit,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUDRATE_DIVISOR);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUDRATE_DIVISOR - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1)
            parity_of = ~^d;
        else
            parity_of = ^d;
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count_d;
    logic                 wr_acc, pop;

    state_t               state, state_d;
    logic [BW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx, bit_idx_d;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_bit_d, shift_en;
    logic                 baud_last, data_last, stop_last;

    // Writes are qualified by the registered full flag, so a pop on the same
    // edge never makes room for a write that arrived while full.
    assign wr_acc    = rst_n && wr_en && !full;
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign data_last = (bit_idx == DATA_LAST);
    assign stop_last = (bit_idx == STOP_LAST);

    always_comb begin
        count_d = count;
        case ({wr_acc, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            wr_overflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count       <= count_d;
            full        <= (count_d == DEPTH_C);
            empty       <= (count_d == '0);
            wr_overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (!empty) state_d = S_START;
            S_START:  if (baud_last) state_d = S_DATA;
            S_DATA:   if (baud_last && data_last)
                          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (baud_last) state_d = S_STOP;
            S_STOP:   if (baud_last && stop_last)
                          state_d = empty ? S_IDLE : S_START;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the value tx_bit takes after the next edge, plus pop and
    // bit index updates. The line bit is always registered.
    always_comb begin
        pop       = 1'b0;
        tx_bit_d  = tx_bit;
        bit_idx_d = bit_idx;
        shift_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    tx_bit_d = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    tx_bit_d  = shreg[0];
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    if (data_last) begin
                        bit_idx_d = '0;
                        tx_bit_d  = (PARITY != 0) ? par_bit : 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                        tx_bit_d  = shreg[1];
                        shift_en  = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_last)
                    tx_bit_d = 1'b1;
            end
            S_STOP: begin
                if (baud_last) begin
                    if (stop_last) begin
                        bit_idx_d = '0;
                        // Next frame starts with no idle gap when data waits.
                        if (!empty) begin
                            pop      = 1'b1;
                            tx_bit_d = 1'b0;
                        end else begin
                            tx_bit_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign tx_busy = (state != S_IDLE);
    assign tx_done = (state == S_STOP) && stop_last && baud_last;

    // Baud counter restarts on every bit boundary and rests at zero in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_bit   <= 1'b1;
        end else begin
            if (state == S_IDLE || baud_last)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            bit_idx <= bit_idx_d;
            tx_bit  <= tx_bit_d;
        end
    end

    // Shift register and parity are loaded from the FIFO head at pop time,
    // so the queued byte is frozen from the moment it was accepted.
    always_ff @(posedge clk) begin
        if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= parity_of(mem[rd_ptr]);
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo. Four instances with BAUDRATE_DIVISOR=4:
//     u0: 8N1, FIFO_DEPTH=4
//     u1: 8 data, even parity, 1 stop, FIFO_DEPTH=16
//     u2: 8 data, odd parity, 1 stop, FIFO_DEPTH=16
//     u3: 7 data, no parity, 2 stop, FIFO_DEPTH=16
//   Single-frame vectors come from a table. Hand sequences cover the
//   FIFO-full / overflow case and reset in mid-frame. A random phase on u0
//   is compared cycle by cycle against a queue-based frame model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] we_v;
    logic [7:0] wd0, wd1, wd2;
    logic [6:0] wd3;
    logic [3:0] full_v, empty_v, ovf_v, tx_v, busy_v, done_v;
    logic [2:0] cnt0;
    logic [4:0] cnt1, cnt2, cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUDRATE_DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(we_v[0]), .wr_data(wd0),
        .full(full_v[0]), .empty(empty_v[0]), .count(cnt0), .wr_overflow(ovf_v[0]),
        .tx_bit(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx_fifo #(.BAUDRATE_DIVISOR(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(we_v[1]), .wr_data(wd1),
        .full(full_v[1]), .empty(empty_v[1]), .count(cnt1), .wr_overflow(ovf_v[1]),
        .tx_bit(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx_fifo #(.BAUDRATE_DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(we_v[2]), .wr_data(wd2),
        .full(full_v[2]), .empty(empty_v[2]), .count(cnt2), .wr_overflow(ovf_v[2]),
        .tx_bit(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    uart_tx_fifo #(.BAUDRATE_DIVISOR(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
        .clk(clk), .rst_n(rst_n), .wr_en(we_v[3]), .wr_data(wd3),
        .full(full_v[3]), .empty(empty_v[3]), .count(cnt3), .wr_overflow(ovf_v[3]),
        .tx_bit(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic [11:0] bits;   // expected line bits, bit 0 = start bit
        int         nbits;
        int         len;     // expected frame length in cycles
    } vec_t;

    vec_t tbl [9];

    // Reference model for u0: a byte queue plus the per-cycle waveform of the
    // frame currently on the line (head = the cycle being shown now).
    localparam int M_DEPTH = 4;
    localparam int M_DIV   = 4;
    logic [7:0] mq [$];
    bit         wave [$];
    bit         m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_frame(input logic [7:0] d);
        bit v;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)
                v = 1'b0;
            else if (b == 9)
                v = 1'b1;
            else
                v = d[b-1];
            for (int k = 0; k < M_DIV; k++)
                wave.push_back(v);
        end
    endtask

    task automatic model_step(input logic rst, input logic we, input logic [7:0] d);
        bit fb;
        if (!rst) begin
            mq.delete();
            wave.delete();
            m_ovf = 1'b0;
            return;
        end
        fb = (mq.size() == M_DEPTH);
        if (wave.size() > 0)
            void'(wave.pop_front());
        if (wave.size() == 0 && mq.size() > 0)
            load_frame(mq.pop_front());
        m_ovf = we && fb;
        if (we && !fb)
            mq.push_back(d);
    endtask

    task automatic write_one(input int inst, input logic [7:0] d);
        we_v = '0;
        we_v[inst] = 1'b1;
        case (inst)
            0: wd0 = d;
            1: wd1 = d;
            2: wd2 = d;
            default: wd3 = d[6:0];
        endcase
        tick();
        we_v = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [11:0] got;
        int busy_cnt, done_cnt, done_at;
        string nm;
        got = '0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        nm = $sformatf("vec%0d", idx);
        write_one(v.inst, v.data);
        chk({nm, "_lat_idle"}, 32'(busy_v[v.inst]), 32'd0);
        tick();
        chk({nm, "_lat_start"}, 32'({busy_v[v.inst], tx_v[v.inst]}), 32'b10);
        for (int c = 1; c <= v.len + 8; c++) begin
            busy_cnt += int'(busy_v[v.inst]);
            if (done_v[v.inst] === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if ((c - 1) % 4 == 2 && (c - 1) / 4 < v.nbits)
                got[(c - 1) / 4] = tx_v[v.inst];
            tick();
        end
        chk({nm, "_bits"}, 32'(got), 32'(v.bits));
        chk({nm, "_busy_len"}, busy_cnt, v.len);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_done_at"}, done_at, v.len);
    endtask

    initial begin
        int         exp_cnt [6];
        logic [9:0] fr [5];
        int         busy_cnt, done_cnt, bad_done, act, p;
        logic       e_tx, e_busy, e_done, e_full, e_empty;
        logic [2:0] e_cnt;

        tbl[0] = '{0, 8'hA5, 12'h34A, 10, 40};
        tbl[1] = '{0, 8'h00, 12'h200, 10, 40};
        tbl[2] = '{0, 8'hFF, 12'h3FE, 10, 40};
        tbl[3] = '{1, 8'h07, 12'h60E, 11, 44};
        tbl[4] = '{2, 8'h07, 12'h40E, 11, 44};
        tbl[5] = '{1, 8'h0F, 12'h41E, 11, 44};
        tbl[6] = '{2, 8'h0F, 12'h61E, 11, 44};
        tbl[7] = '{3, 8'h55, 12'h3AA, 10, 40};
        tbl[8] = '{3, 8'h2A, 12'h354, 10, 40};
        exp_cnt = '{1, 1, 2, 3, 4, 4};

        // Reset with a write held on u0: the write must be ignored.
        rst_n = 1'b0;
        we_v  = 4'b0001;
        wd0   = 8'h99;
        wd1   = '0;
        wd2   = '0;
        wd3   = '0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx_v), 32'hF);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        chk("rst_empty", 32'(empty_v), 32'hF);
        chk("rst_full", 32'(full_v), 32'h0);
        chk("rst_ovf", 32'(ovf_v), 32'h0);
        chk("rst_cnt", 32'({cnt0, cnt1, cnt2, cnt3}), 32'h0);
        rst_n = 1'b1;
        we_v  = '0;
        tick();
        chk("rst_wr_ignored_cnt", 32'(cnt0), 32'd0);
        chk("rst_wr_ignored_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) tick();

        for (int i = 0; i < 9; i++)
            run_vec(tbl[i], i);

        // FIFO_DEPTH=4: six consecutive writes, the sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            we_v[0] = 1'b1;
            wd0 = 8'(i);
            tick();
            chk($sformatf("seqA_cnt_w%0d", i), 32'(cnt0), exp_cnt[i-1]);
            chk($sformatf("seqA_full_w%0d", i), 32'(full_v[0]), (i >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("seqA_ovf_w%0d", i), 32'(ovf_v[0]), (i == 6) ? 32'd1 : 32'd0);
            if (i == 2)
                chk("seqA_first_start", 32'({busy_v[0], tx_v[0]}), 32'b10);
        end
        we_v[0] = 1'b0;
        wd0 = 8'hEE;
        tick();
        chk("seqA_ovf_clear", 32'(ovf_v[0]), 32'd0);
        for (int f = 0; f < 5; f++)
            fr[f] = '0;
        busy_cnt = 0;
        done_cnt = 0;
        bad_done = 0;
        for (int rel = 5; rel < 215; rel++) begin
            busy_cnt += int'(busy_v[0]);
            if (done_v[0] === 1'b1) begin
                done_cnt++;
                if (rel % 40 != 39)
                    bad_done++;
            end
            if (rel < 200 && rel % 4 == 2)
                fr[rel / 40][(rel % 40) / 4] = tx_v[0];
            if (rel == 159)
                chk("seqA_before_last_pop", 32'({cnt0, empty_v[0]}), 32'b0010);
            if (rel == 160)
                chk("seqA_after_last_pop", 32'({cnt0, empty_v[0]}), 32'b0001);
            tick();
        end
        for (int f = 0; f < 5; f++)
            chk($sformatf("seqA_frame%0d", f), 32'(fr[f][9:1]), 32'({1'b1, 8'(f + 1)}));
        chk("seqA_busy_cycles", busy_cnt, 195);
        chk("seqA_done_cnt", done_cnt, 5);
        chk("seqA_done_spacing", bad_done, 0);
        chk("seqA_idle_after", 32'({busy_v[0], tx_v[0]}), 32'b01);

        // Reset during data bit 3 with two entries queued.
        we_v[0] = 1'b1;
        wd0 = 8'h11;
        tick();
        wd0 = 8'h22;
        tick();
        wd0 = 8'h33;
        tick();
        we_v[0] = 1'b0;
        repeat (16) tick();
        chk("seqB_queued", 32'(cnt0), 32'd2);
        chk("seqB_in_bit3", 32'({busy_v[0], tx_v[0]}), 32'b10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("seqB_tx_high", 32'(tx_v[0]), 32'd1);
        chk("seqB_cnt_zero", 32'(cnt0), 32'd0);
        chk("seqB_empty", 32'(empty_v[0]), 32'd1);
        chk("seqB_not_busy", 32'(busy_v[0]), 32'd0);
        chk("seqB_no_done", 32'(done_v[0]), 32'd0);
        act = 0;
        for (int c = 0; c < 100; c++) begin
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || cnt0 !== 3'd0)
                act++;
            tick();
        end
        chk("seqB_line_quiet", act, 0);

        // Random traffic on u0 against the queue model.
        mq.delete();
        wave.delete();
        m_ovf = 1'b0;
        p = 90;
        for (int i = 0; i < 3000; i++) begin
            case ((i / 200) % 3)
                0: p = 90;
                1: p = 5;
                default: p = 30;
            endcase
            rst_n   = ($urandom_range(0, 999) != 0);
            we_v[0] = ($urandom_range(0, 99) < p);
            wd0     = 8'($urandom);
            @(posedge clk);
            model_step(rst_n, we_v[0], wd0);
            @(negedge clk);
            e_tx    = (wave.size() > 0) ? wave[0] : 1'b1;
            e_busy  = (wave.size() > 0);
            e_done  = (wave.size() == 1);
            e_cnt   = 3'(mq.size());
            e_full  = (mq.size() == M_DEPTH);
            e_empty = (mq.size() == 0);
            chk("rnd_tx", 32'(tx_v[0]), 32'(e_tx));
            chk("rnd_busy", 32'(busy_v[0]), 32'(e_busy));
            chk("rnd_done", 32'(done_v[0]), 32'(e_done));
            chk("rnd_cnt", 32'(cnt0), 32'(e_cnt));
            chk("rnd_full", 32'(full_v[0]), 32'(e_full));
            chk("rnd_empty", 32'(empty_v[0]), 32'(e_empty));
            chk("rnd_ovf", 32'(ovf_v[0]), 32'(m_ovf));
        end
        rst_n   = 1'b1;
        we_v[0] = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
